// File: rtl/tick_cycle_sequencer.sv
// Operating-cycle sequencer driven by the 4 s system tick: WORK/REST phases
// repeated a programmed number of times, with pause, cancel and a done pulse.
module tick_cycle_sequencer #(
  parameter int CNT_W = 8,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             pause,
  input  logic             cancel,
  input  logic [CNT_W-1:0] work_len,
  input  logic [CNT_W-1:0] rest_len,
  input  logic [REP_W-1:0] reps,
  output logic [2:0]       state,
  output logic             busy,
  output logic             working,
  output logic             resting,
  output logic [CNT_W-1:0] remaining,
  output logic [REP_W-1:0] reps_left,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WORK  = 3'd1,
    S_REST  = 3'd2,
    S_DONE  = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  state_t           state_q, state_d;
  logic             rest_phase_q, rest_phase_d;  // frozen phase while paused: 1 = REST
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [REP_W-1:0] reps_left_q, reps_left_d;
  logic [CNT_W-1:0] work_len_q, work_len_d;
  logic [CNT_W-1:0] rest_len_q, rest_len_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // State and datapath register.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rest_phase_q <= 1'b0;
      remaining_q  <= '0;
      reps_left_q  <= '0;
      work_len_q   <= '0;
      rest_len_q   <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rest_phase_q <= rest_phase_d;
      remaining_q  <= remaining_d;
      reps_left_q  <= reps_left_d;
      work_len_q   <= work_len_d;
      rest_len_q   <= rest_len_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic. Priority within a cycle: cancel > start > pause > tick.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    rest_phase_d = rest_phase_q;
    remaining_d  = remaining_q;
    reps_left_d  = reps_left_q;
    work_len_d   = work_len_q;
    rest_len_d   = rest_len_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          if (work_len != '0 && reps != '0) begin
            state_d     = S_WORK;
            work_len_d  = work_len;
            rest_len_d  = rest_len;
            remaining_d = work_len;
            reps_left_d = reps;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_WORK, S_REST: begin
        if (cancel) begin
          state_d     = S_IDLE;
          remaining_d = '0;
          reps_left_d = '0;
        end else if (pause) begin
          state_d      = S_PAUSE;
          rest_phase_d = (state_q == S_REST);
        end else if (tick) begin
          if (remaining_q > CNT_ONE) begin
            remaining_d = remaining_q - CNT_ONE;
          end else if (state_q == S_REST) begin
            state_d     = S_WORK;
            remaining_d = work_len_q;
            reps_left_d = reps_left_q - REP_ONE;
          end else if (reps_left_q <= REP_ONE) begin
            // Last WORK phase: finish without a trailing REST.
            state_d     = S_DONE;
            remaining_d = '0;
            reps_left_d = '0;
            done_d      = 1'b1;
          end else if (rest_len_q != '0) begin
            state_d     = S_REST;
            remaining_d = rest_len_q;
          end else begin
            state_d     = S_WORK;
            remaining_d = work_len_q;
            reps_left_d = reps_left_q - REP_ONE;
          end
        end
      end

      S_PAUSE: begin
        if (cancel) begin
          state_d     = S_IDLE;
          remaining_d = '0;
          reps_left_d = '0;
        end else if (!pause) begin
          state_d = rest_phase_q ? S_REST : S_WORK;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d     = S_IDLE;
        remaining_d = '0;
        reps_left_d = '0;
      end
    endcase
  end

  // Output decode: flags depend only on the state and the saved phase bit.
  always_comb begin
    busy    = 1'b0;
    working = 1'b0;
    resting = 1'b0;
    case (state_q)
      S_WORK:  begin busy = 1'b1; working = 1'b1; end
      S_REST:  begin busy = 1'b1; resting = 1'b1; end
      S_PAUSE: begin
        busy    = 1'b1;
        working = !rest_phase_q;
        resting = rest_phase_q;
      end
      default: ;
    endcase
  end

  assign state     = state_q;
  assign remaining = remaining_q;
  assign reps_left = reps_left_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_tick_cycle_sequencer.sv
// Self-checking bench for tick_cycle_sequencer: a phase-list model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_tick_cycle_sequencer;

  localparam int CNT_W = 8;
  localparam int REP_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             tick = 1'b0, start = 1'b0, pause = 1'b0, cancel = 1'b0;
  logic [CNT_W-1:0] work_len = '0, rest_len = '0;
  logic [REP_W-1:0] reps = '0;
  logic [2:0]       state;
  logic             busy, working, resting, done, err;
  logic [CNT_W-1:0] remaining;
  logic [REP_W-1:0] reps_left;

  int n_cmp  = 0;
  int n_fail = 0;

  tick_cycle_sequencer #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .pause(pause),
    .cancel(cancel), .work_len(work_len), .rest_len(rest_len), .reps(reps),
    .state(state), .busy(busy), .working(working), .resting(resting),
    .remaining(remaining), .reps_left(reps_left), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input int expv);
    n_cmp++;
    if (act !== 32'(expv)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Model: an accepted start expands into a list of phases (kind, length);
  // progress is an index into the list plus ticks elapsed in that phase.
  int q_len[64];
  bit q_rest[64];
  int q_n, m_idx, m_el;
  bit m_active, m_paused, m_done, m_err;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0; m_paused = 0; m_done = 0; m_err = 0;
      q_n = 0; m_idx = 0; m_el = 0;
    end else begin
      m_err = 0;
      if (m_done) begin
        m_done = 0;
      end else if (!m_active) begin
        if (start && !cancel) begin
          if (work_len != 0 && reps != 0) begin
            q_n = 0;
            for (int i = 0; i < int'(reps); i++) begin
              q_len[q_n] = int'(work_len); q_rest[q_n] = 0; q_n++;
              if (i < int'(reps) - 1 && rest_len != 0) begin
                q_len[q_n] = int'(rest_len); q_rest[q_n] = 1; q_n++;
              end
            end
            m_idx = 0; m_el = 0; m_active = 1; m_paused = 0;
          end else begin
            m_err = 1;
          end
        end
      end else if (cancel) begin
        m_active = 0; m_paused = 0;
      end else if (m_paused) begin
        if (!pause) m_paused = 0;
      end else if (pause) begin
        m_paused = 1;
      end else if (tick) begin
        m_el++;
        if (m_el == q_len[m_idx]) begin
          m_el = 0;
          m_idx++;
          if (m_idx == q_n) begin
            m_active = 0;
            m_done = 1;
          end
        end
      end
    end
  end

  function automatic int exp_state();
    if (m_done) return 3;
    if (!m_active) return 0;
    if (m_paused) return 4;
    return q_rest[m_idx] ? 2 : 1;
  endfunction

  // A REST phase still counts the WORK phase that preceded it.
  function automatic int exp_reps_left();
    int cnt = 0;
    if (!m_active) return 0;
    for (int j = m_idx; j < q_n; j++) if (!q_rest[j]) cnt++;
    if (q_rest[m_idx]) cnt++;
    return cnt;
  endfunction

  always @(negedge clk) begin
    check("state",     32'(state),     exp_state());
    check("busy",      32'(busy),      int'(m_active));
    check("working",   32'(working),   int'(m_active && !q_rest[m_idx]));
    check("resting",   32'(resting),   int'(m_active && q_rest[m_idx]));
    check("remaining", 32'(remaining), m_active ? q_len[m_idx] - m_el : 0);
    check("reps_left", 32'(reps_left), exp_reps_left());
    check("done",      32'(done),      int'(m_done));
    check("err",       32'(err),       int'(m_err));
  end

  // Present one set of pulse inputs for exactly one rising edge.
  task automatic cyc(input bit s, input bit c, input bit t);
    start = s; cancel = c; tick = t;
    @(posedge clk); #2;
    start = 0; cancel = 0; tick = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0);
  endtask

  task automatic cfg(input int w, input int r, input int n);
    work_len = CNT_W'(w); rest_len = CNT_W'(r); reps = REP_W'(n);
  endtask

  initial begin
    @(posedge clk); #2;
    @(negedge clk);
    check("reset_state", 32'(state), 0);
    check("reset_remaining", 32'(remaining), 0);
    reset = 0;
    idle(2);

    // Full cycle with rest, ticks every 40 clk.
    cfg(3, 2, 2);
    cyc(1, 0, 0);
    @(negedge clk);
    check("t1_start_state", 32'(state), 1);
    check("t1_start_rem", 32'(remaining), 3);
    check("t1_start_reps", 32'(reps_left), 2);
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) idle(39);
      cyc(0, 0, 1);
      @(negedge clk);
      if (k == 3) begin
        check("t1_rest_state", 32'(state), 2);
        check("t1_rest_rem", 32'(remaining), 2);
        check("t1_rest_reps", 32'(reps_left), 2);
      end
      if (k == 5) begin
        check("t1_work2_state", 32'(state), 1);
        check("t1_work2_reps", 32'(reps_left), 1);
      end
      if (k == 8) begin
        check("t1_done", 32'(done), 1);
        check("t1_done_state", 32'(state), 3);
        check("t1_done_reps", 32'(reps_left), 0);
      end
    end
    @(negedge clk);
    check("t1_after_done", 32'(done), 0);
    check("t1_idle_state", 32'(state), 0);
    idle(2);

    // No rest: REST must be skipped.
    cfg(2, 0, 3);
    cyc(1, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      idle(2);
      cyc(0, 0, 1);
      @(negedge clk);
      if (k == 2) check("t2_reps_k2", 32'(reps_left), 2);
      if (k == 4) check("t2_reps_k4", 32'(reps_left), 1);
      if (k == 6) check("t2_done", 32'(done), 1);
      if (k < 6) check("t2_no_rest", 32'(state == 3'd2), 0);
    end
    idle(2);

    // Pause during WORK with remaining=5.
    cfg(6, 0, 1);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    pause = 1;
    cyc(0, 0, 1);
    @(negedge clk);
    check("t3_pause_state", 32'(state), 4);
    check("t3_pause_working", 32'(working), 1);
    check("t3_pause_rem", 32'(remaining), 5);
    repeat (3) cyc(0, 0, 1);
    @(negedge clk);
    check("t3_pause_hold_rem", 32'(remaining), 5);
    pause = 0;
    cyc(0, 0, 1);
    @(negedge clk);
    check("t3_resume_state", 32'(state), 1);
    check("t3_resume_rem", 32'(remaining), 5);
    cyc(0, 0, 1);
    @(negedge clk);
    check("t3_after_tick_rem", 32'(remaining), 4);
    cyc(0, 1, 0);
    idle(1);

    // Cancel in REST, then same-cycle events.
    cfg(3, 2, 2);
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 1);
    @(negedge clk);
    check("t4_rest_rem", 32'(remaining), 2);
    cyc(0, 1, 0);
    @(negedge clk);
    check("t4_cancel_state", 32'(state), 0);
    check("t4_cancel_busy", 32'(busy), 0);
    cyc(1, 1, 0);
    @(negedge clk);
    check("t4_cancel_start", 32'(state), 0);
    cfg(4, 0, 1);
    cyc(1, 0, 1);
    @(negedge clk);
    check("t4_tick_start_rem", 32'(remaining), 4);
    cfg(9, 7, 5);
    cyc(1, 0, 0);
    @(negedge clk);
    check("t4_busy_start_rem", 32'(remaining), 4);
    check("t4_busy_start_reps", 32'(reps_left), 1);
    check("t4_busy_start_err", 32'(err), 0);
    cyc(0, 0, 1);
    @(negedge clk);
    check("t4_latched_rem", 32'(remaining), 3);
    cyc(0, 1, 0);

    // Rejected starts.
    cfg(3, 1, 0);
    cyc(1, 0, 0);
    @(negedge clk);
    check("t5_err_reps0", 32'(err), 1);
    check("t5_err_state", 32'(state), 0);
    @(negedge clk);
    check("t5_err_clear", 32'(err), 0);
    cfg(0, 1, 2);
    cyc(1, 0, 0);
    @(negedge clk);
    check("t5_err_work0", 32'(err), 1);
    idle(1);

    // Asynchronous reset between edges during WORK.
    cfg(5, 1, 2);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    reset = 1;
    #1;
    check("t6_rst_state", 32'(state), 0);
    check("t6_rst_rem", 32'(remaining), 0);
    check("t6_rst_reps", 32'(reps_left), 0);
    check("t6_rst_busy", 32'(busy), 0);
    idle(1);
    reset = 0;
    idle(1);
    cyc(1, 0, 0);
    @(negedge clk);
    check("t6_restart_state", 32'(state), 1);
    check("t6_restart_rem", 32'(remaining), 5);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_cycle_sequencer.md
Name: tick_cycle_sequencer

Overview:
- Downstream consumer of the 40-cycle (4 s) tick produced by the system timer.
- Runs a programmable operating cycle: a WORK phase followed by a REST phase, repeated a set number of times.
- Every phase length is counted in 4 s ticks.
- Exposes phase flags, remaining ticks and repetitions to the display and actuator logic, and pulses `done` when the whole cycle completes.

Parameters:
- CNT_W, 8, width of phase-length counters, in ticks.
- REP_W, 4, width of the repetition counter.

Ports:
- clk  input  1  system clock, same clock that drives the 4 s timer.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  one-clk-wide pulse from the 4 s timer.
- start  input  1  one-clk request to begin a cycle.
- pause  input  1  level; freezes the current phase while high.
- cancel  input  1  one-clk abort request.
- work_len  input  CNT_W  WORK phase length in ticks; sampled on accepted start.
- rest_len  input  CNT_W  REST phase length in ticks; sampled on accepted start.
- reps  input  REP_W  number of WORK phases; sampled on accepted start.
- state  output  3  0=IDLE, 1=WORK, 2=REST, 3=DONE, 4=PAUSE.
- busy  output  1  high in WORK, REST and PAUSE.
- working  output  1  high in WORK, and in PAUSE when the frozen phase is WORK.
- resting  output  1  high in REST, and in PAUSE when the frozen phase is REST.
- remaining  output  CNT_W  ticks left in the current phase.
- reps_left  output  REP_W  WORK phases left, including the current one.
- done  output  1  high exactly one clk, while state is DONE.
- err  output  1  one-clk pulse when a start is rejected.

Behaviour:
- Clocking: single clock domain; all state updates on the rising edge of clk.
- Reset: asynchronous, active-high. While reset is high:
  - state=IDLE.
  - busy, working, resting, done, err = 0.
  - remaining=0, reps_left=0, latched lengths=0, saved phase bit=0.
- Priority each cycle: cancel > start > pause > tick.
- IDLE:
  - start with work_len!=0 and reps!=0 latches work_len, rest_len and reps.
  - It then loads remaining=work_len and reps_left=reps, and moves to WORK on the next edge.
  - start with work_len==0 or reps==0: err=1 for one clk, stay IDLE.
  - tick ignored.
- WORK and REST:
  - pause=1: go to PAUSE and save the phase bit; remaining is unchanged; any tick in that cycle is dropped.
  - tick with remaining>1: remaining -= 1.
  - tick with remaining==1 in WORK:
    - If reps_left==1, go to DONE with remaining=0 and reps_left=0. The final WORK is never followed by REST.
    - Else if latched rest_len!=0, go to REST with remaining=rest_len.
    - Else (rest_len==0, REST skipped), reps_left -= 1 and re-enter WORK with remaining=work_len.
  - tick with remaining==1 in REST: reps_left -= 1, go to WORK with remaining=work_len.
- PAUSE:
  - All ticks ignored.
  - When pause==0, return to the saved phase on the next edge with remaining unchanged. Ticks in that return cycle are ignored.
- DONE: lasts exactly one clk with done=1, then IDLE. start, pause and tick are ignored during DONE.
- start while busy: ignored; no err, latched values unchanged.
- cancel:
  - In any state other than IDLE, next state is IDLE with remaining=0 and reps_left=0. No done pulse, no err.
  - cancel in IDLE has no effect.
  - cancel and start in the same cycle: cancel wins, start is dropped.
- Counters never wrap. remaining never decrements below 1 within a phase; phase exit happens on the tick that sees remaining==1.
- Input changes mid-cycle: changes to work_len, rest_len or reps after an accepted start have no effect until the next accepted start.
- Latency:
  - start to WORK: 1 clk.
  - Phase change: on the edge that samples the final tick.
  - done: asserted 1 clk after the final tick.
- Reset mid-operation: immediate return to the reset values above; no done pulse.
- All outputs are registered except the derived flags busy, working and resting, which are decoded from state and the saved phase bit only.

Test Plan:
- Full cycle with rest: work_len=3, rest_len=2, reps=2, start, then ticks every 40 clk.
  - Required: WORK for 3 ticks, REST for 2 ticks, WORK for 3 ticks, then DONE. No REST after the last WORK.
  - Required: done high for 1 clk, 1 clk after the 8th tick; reps_left goes 2→1→0.
- No rest: rest_len=0, work_len=2, reps=3.
  - Required: state never 2; reps_left 3→2→1→0 on ticks 2, 4 and 6; done after tick 6.
- Pause: pause=1 during WORK with remaining=5, then 3 ticks while paused, then pause released.
  - Required: state=4, working=1, remaining stays 5; return to WORK with remaining=5; the next tick gives 4.
- Cancel and same-cycle events:
  - cancel in REST with remaining=2: IDLE next edge, busy=0, done never asserted.
  - cancel+start in the same cycle: stays IDLE.
  - tick+start in the same cycle: remaining=work_len, not decremented.
- Rejects:
  - start with reps=0 → err=1 for 1 clk, state stays 0.
  - start while busy → ignored; remaining and reps_left unchanged.
- Async reset asserted mid-WORK between clk edges: outputs go to 0 and state to IDLE immediately, without waiting for a clk edge; normal start works after release.
